// File: rtl/jt7759_seq.sv
// rtl/jt7759_seq.sv - sample-number command queue and start/busy sequencer for jt7759
//
// Queues sample numbers and plays them one at a time on a jt7759: load the
// head into din, pulse stn low, wait for busyn to go low (with a timeout),
// wait for busyn to return high, then leave an idle gap before the next sample.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rstn       asynchronous active-low reset
//   i_cen        640kHz clock enable shared with jt7759; every tick counter uses it
//   i_cmd_we     one-cycle push strobe
//   i_cmd_data   sample number to push
//   i_stop       flush queue and abort sequencing
//   o_cmd_full   queue full
//   o_level      number of queued entries (0..2**QAW)
//   o_stn        jt7759 start, active low
//   o_din        sample number presented to jt7759
//   i_busyn      jt7759 busy, active low
//   o_playing    high from start pulse until sample end
//   o_done       one-clk pulse at sample end
//   o_err        one-clk pulse when busyn never went low after a start
//   o_ovf        one-clk pulse when a push was dropped
`timescale 1ns/1ps
module jt7759_seq #(
    parameter int QAW  = 2,
    parameter int STW  = 2,
    parameter int TOUT = 64,
    parameter int GAPW = 4
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_cen,
    input  logic           i_cmd_we,
    input  logic [7:0]     i_cmd_data,
    input  logic           i_stop,
    output logic           o_cmd_full,
    output logic [QAW:0]   o_level,
    output logic           o_stn,
    output logic [7:0]     o_din,
    input  logic           i_busyn,
    output logic           o_playing,
    output logic           o_done,
    output logic           o_err,
    output logic           o_ovf
);

    localparam int DEPTH  = 1 << QAW;
    // Zero-length pulse or gap would break the handshake, so clamp to one tick
    localparam int STW_E  = (STW  < 1) ? 1 : STW;
    localparam int GAPW_E = (GAPW < 1) ? 1 : GAPW;
    localparam int TOUT_E = (TOUT < 1) ? 1 : TOUT;
    localparam int TMAX   = (TOUT_E > STW_E) ? ((TOUT_E > GAPW_E) ? TOUT_E : GAPW_E)
                                             : ((STW_E  > GAPW_E) ? STW_E  : GAPW_E);
    localparam int CW     = $clog2(TMAX + 1);

    localparam logic [QAW:0]   LVL_FULL = (QAW+1)'(DEPTH);
    localparam logic [QAW:0]   LVL_ONE  = (QAW+1)'(1);
    localparam logic [QAW-1:0] PTR_ONE  = QAW'(1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAITB, S_PLAY, S_GAP
    } state_t;

    state_t         r_state, w_state_n;
    logic [7:0]     r_mem [DEPTH];
    logic [QAW-1:0] r_wr_ptr, r_rd_ptr;
    logic [QAW:0]   r_level;
    logic [CW-1:0]  r_cnt;
    logic           r_stn, r_playing, r_done, r_err, r_ovf;
    logic [7:0]     r_din;

    logic w_full, w_pop, w_push, w_drop;
    logic w_stn_n, w_playing_n, w_done_n, w_err_n;
    logic w_timed;

    assign w_full = (r_level == LVL_FULL);
    // LOAD is only entered with a non-empty queue and lasts one clk
    assign w_pop  = (r_state == S_LOAD) && !i_stop;
    // A same-cycle pop frees a slot, so a push into a full queue still lands
    assign w_push = i_cmd_we && !i_stop && (!w_full || w_pop);
    assign w_drop = i_cmd_we && !i_stop && w_full && !w_pop;
    assign w_timed = (r_state == S_START) || (r_state == S_WAITB) || (r_state == S_GAP);

    always_comb begin
        w_state_n   = r_state;
        w_stn_n     = r_stn;
        w_playing_n = r_playing;
        w_done_n    = 1'b0;
        w_err_n     = 1'b0;
        if (i_stop) begin
            w_state_n   = S_IDLE;
            w_stn_n     = 1'b1;
            w_playing_n = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // busyn low here means a sample is still sounding; let it end
                    if (r_level != '0 && i_busyn) w_state_n = S_LOAD;
                end
                S_LOAD: begin
                    w_state_n   = S_START;
                    w_stn_n     = 1'b0;
                    w_playing_n = 1'b1;
                end
                S_START: begin
                    if (i_cen && r_cnt == CW'(STW_E - 1)) begin
                        w_state_n = S_WAITB;
                        w_stn_n   = 1'b1;
                    end
                end
                S_WAITB: begin
                    if (!i_busyn) begin
                        w_state_n = S_PLAY;
                    end else if (i_cen && r_cnt == CW'(TOUT_E - 1)) begin
                        w_state_n   = S_IDLE;
                        w_err_n     = 1'b1;
                        w_playing_n = 1'b0;
                    end
                end
                S_PLAY: begin
                    if (i_busyn) begin
                        w_state_n   = S_GAP;
                        w_done_n    = 1'b1;
                        w_playing_n = 1'b0;
                    end
                end
                S_GAP: begin
                    if (i_cen && r_cnt == CW'(GAPW_E - 1)) w_state_n = S_IDLE;
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_stn     <= 1'b1;
            r_playing <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_stn     <= w_stn_n;
            r_playing <= w_playing_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
            // Every state entry starts its tick count from zero
            if (w_state_n != r_state) begin
                r_cnt <= '0;
            end else if (i_cen && w_timed) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
            r_din    <= '0;
        end else begin
            r_ovf <= w_drop;
            if (w_pop) r_din <= r_mem[r_rd_ptr];
            if (i_stop) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LVL_ONE;
                    2'b01:   r_level <= r_level - LVL_ONE;
                    default: r_level <= r_level;
                endcase
            end
        end
    end

    // Storage needs no reset: level and pointers define which entries are valid
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_cmd_data;
    end

    assign o_cmd_full = w_full;
    assign o_level    = r_level;
    assign o_stn      = r_stn;
    assign o_din      = r_din;
    assign o_playing  = r_playing;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_jt7759_seq.sv
// tb/tb_jt7759_seq.sv - directed self-checking bench for jt7759_seq with a jt7759 busyn model
`timescale 1ns/1ps
module tb_jt7759_seq;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       cen = 1'b0;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       stop = 1'b0;
    logic       cmd_full;
    logic [2:0] level;
    logic       stn;
    logic [7:0] din;
    logic       busyn;
    logic       playing, done, err, ovf;

    logic busyn_mdl = 1'b1;
    logic force_busy = 1'b0;
    logic model_en = 1'b1;
    assign busyn = busyn_mdl & ~force_busy;

    int n_cmp = 0;
    int n_fail = 0;

    // Event log filled by the monitor
    int tick_n = 0, div = 0, low_cnt = 0, stn_w = 0, rise_tick = 0, done_tick = 0;
    int fall_cnt = 0, done_cnt = 0, err_cnt = 0, ovf_cnt = 0, err_delay = 0;
    int mdl_phase = 0, mdl_cnt = 0;
    logic done_seen = 1'b0;
    logic prev_stn = 1'b1;
    logic [7:0] played_q[$];
    int gap_q[$];

    jt7759_seq dut (
        .i_clk(clk), .i_rstn(rstn), .i_cen(cen), .i_cmd_we(cmd_we), .i_cmd_data(cmd_data),
        .i_stop(stop), .o_cmd_full(cmd_full), .o_level(level), .o_stn(stn), .o_din(din),
        .i_busyn(busyn), .o_playing(playing), .o_done(done), .o_err(err), .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    // Negedge: observe what the last rising edge produced, run the jt7759 busyn
    // model, then set cen for the next rising edge (one tick every 4 clks).
    always @(negedge clk) begin
        if (cen) tick_n++;
        if (cen && !prev_stn) low_cnt++;
        if (prev_stn && !stn) begin
            fall_cnt++;
            played_q.push_back(din);
            low_cnt = 0;
            if (done_seen) gap_q.push_back(tick_n - done_tick);
        end
        if (!prev_stn && stn) begin
            stn_w = low_cnt;
            rise_tick = tick_n;
            if (model_en) begin mdl_phase = 1; mdl_cnt = 0; end
        end else if (mdl_phase == 1 && cen) begin
            mdl_cnt++;
            if (mdl_cnt == 3) begin busyn_mdl = 1'b0; mdl_phase = 2; mdl_cnt = 0; end
        end else if (mdl_phase == 2 && cen) begin
            mdl_cnt++;
            if (mdl_cnt == 100) begin busyn_mdl = 1'b1; mdl_phase = 0; end
        end
        if (done) begin done_cnt++; done_tick = tick_n; done_seen = 1'b1; end
        if (err) begin err_cnt++; err_delay = tick_n - rise_tick; end
        if (ovf) ovf_cnt++;
        prev_stn = stn;
        cen = (div == 3);
        div = (div + 1) % 4;
    end

    task automatic clks(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [7:0] d);
        cmd_we = 1'b1; cmd_data = d;
        @(posedge clk); #1;
        cmd_we = 1'b0;
    endtask

    task automatic wait_quiet(input string tag);
        int t = 0;
        while (!(playing === 1'b0 && level === 3'd0 && mdl_phase == 0 && busyn === 1'b1) && t < 3000) begin
            clks(1); t++;
        end
        n_cmp++; if (t >= 3000) begin n_fail++; $display("FAIL %s_quiet: timed out after %0d clks, want idle", tag, t); end
        clks(30);
    endtask

    task automatic wait_done(input int base, input int want, input int lim);
        int t = 0;
        while (done_cnt - base < want && t < lim) begin clks(1); t++; end
    endtask

    task automatic test_reset;
        clks(3);
        n_cmp++; if (stn !== 1'b1) begin n_fail++; $display("FAIL reset_stn: got %b want 1", stn); end
        n_cmp++; if (din !== 8'h00) begin n_fail++; $display("FAIL reset_din: got %h want 00", din); end
        n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (cmd_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", cmd_full); end
        n_cmp++; if ({playing, done, err, ovf} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {playing, done, err, ovf}); end
        rstn = 1'b1;
        clks(4);
    endtask

    task automatic test_single;
        int db = done_cnt, fb = fall_cnt, t = 0;
        push(8'h05);
        n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL single_level1: got %0d want 1", level); end
        while (fall_cnt == fb && t < 100) begin clks(1); t++; end
        n_cmp++; if (playing !== 1'b1) begin n_fail++; $display("FAIL single_playing: got %b want 1", playing); end
        wait_done(db, 1, 1500);
        n_cmp++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL single_done: got %0d pulses want 1", done_cnt - db); end
        n_cmp++; if (played_q[played_q.size()-1] !== 8'h05) begin n_fail++; $display("FAIL single_din: got %h want 05", played_q[played_q.size()-1]); end
        n_cmp++; if (stn_w !== 2) begin n_fail++; $display("FAIL single_stn_width: got %0d ticks want 2", stn_w); end
        clks(2);
        n_cmp++; if ({level, playing} !== 4'b0000) begin n_fail++; $display("FAIL single_end: got level %0d playing %b want 0 0", level, playing); end
        wait_quiet("single");
    endtask

    task automatic test_back_to_back;
        int db = done_cnt, pb = played_q.size(), gb = gap_q.size();
        logic gap_ok = 1'b1;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(i));
        n_cmp++; if (cmd_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b want 1", cmd_full); end
        n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL b2b_level: got %0d want 4", level); end
        clks(20);
        n_cmp++; if (played_q.size() !== pb) begin n_fail++; $display("FAIL b2b_residual_hold: got %0d starts want 0", played_q.size() - pb); end
        force_busy = 1'b0;
        wait_done(db, 4, 3000);
        n_cmp++; if (done_cnt - db !== 4) begin n_fail++; $display("FAIL b2b_done: got %0d want 4", done_cnt - db); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (played_q.size() <= pb + i || played_q[pb+i] !== 8'(i)) begin n_fail++; $display("FAIL b2b_order%0d: got %h want %h", i, (played_q.size() > pb + i) ? played_q[pb+i] : 8'hxx, 8'(i)); end
        end
        for (int i = gb; i < gap_q.size(); i++) if (gap_q[i] < 4) gap_ok = 1'b0;
        n_cmp++; if (gap_ok !== 1'b1 || gap_q.size() - gb < 3) begin n_fail++; $display("FAIL b2b_gap: got ok=%b n=%0d want gaps>=4 n>=3", gap_ok, gap_q.size() - gb); end
        wait_quiet("b2b");
    endtask

    task automatic test_overflow;
        int db = done_cnt, ob = ovf_cnt, pb = played_q.size();
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        clks(2);
        n_cmp++; if (ovf_cnt - ob !== 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", ovf_cnt - ob); end
        n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", level); end
        force_busy = 1'b0;
        wait_done(db, 4, 3000);
        clks(200);
        n_cmp++; if (played_q.size() - pb !== 4) begin n_fail++; $display("FAIL ovf_starts: got %0d want 4", played_q.size() - pb); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (played_q.size() <= pb + i || played_q[pb+i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL ovf_order%0d: got %h want %h", i, (played_q.size() > pb + i) ? played_q[pb+i] : 8'hxx, 8'h10 + 8'(i)); end
        end
        wait_quiet("ovf");
    endtask

    task automatic test_timeout;
        int db = done_cnt, eb = err_cnt, pb = played_q.size(), t = 0;
        model_en = 1'b0;
        push(8'hA0);
        push(8'hB1);
        while (err_cnt == eb && t < 600) begin clks(1); t++; end
        n_cmp++; if (err_cnt - eb !== 1) begin n_fail++; $display("FAIL tout_err: got %0d pulses want 1", err_cnt - eb); end
        n_cmp++; if (err_delay !== 64) begin n_fail++; $display("FAIL tout_delay: got %0d ticks want 64", err_delay); end
        n_cmp++; if (playing !== 1'b0) begin n_fail++; $display("FAIL tout_playing: got %b want 0", playing); end
        model_en = 1'b1;
        wait_done(db, 1, 1500);
        n_cmp++; if (done_cnt - db !== 1 || err_cnt - eb !== 1) begin n_fail++; $display("FAIL tout_next: got done %0d err %0d want 1 1", done_cnt - db, err_cnt - eb); end
        n_cmp++; if (played_q.size() - pb !== 2 || played_q[pb] !== 8'hA0 || played_q[pb+1] !== 8'hB1) begin n_fail++; $display("FAIL tout_seq: got %0d starts want A0 then B1", played_q.size() - pb); end
        wait_quiet("tout");
    endtask

    task automatic test_stop;
        int db, ob, fb, t = 0;
        push(8'hC0); push(8'hC1); push(8'hC2);
        while (!(busyn === 1'b0 && playing === 1'b1) && t < 300) begin clks(1); t++; end
        clks(10);
        n_cmp++; if (level !== 3'd2) begin n_fail++; $display("FAIL stop_pre_level: got %0d want 2", level); end
        db = done_cnt; ob = ovf_cnt; fb = fall_cnt;
        stop = 1'b1; cmd_we = 1'b1; cmd_data = 8'hEE;
        @(posedge clk); #1;
        stop = 1'b0; cmd_we = 1'b0;
        n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL stop_level: got %0d want 0", level); end
        n_cmp++; if ({playing, stn} !== 2'b01) begin n_fail++; $display("FAIL stop_outputs: got playing %b stn %b want 0 1", playing, stn); end
        clks(600);
        n_cmp++; if (done_cnt - db !== 0 || ovf_cnt - ob !== 0) begin n_fail++; $display("FAIL stop_pulses: got done %0d ovf %0d want 0 0", done_cnt - db, ovf_cnt - ob); end
        n_cmp++; if (fall_cnt - fb !== 0) begin n_fail++; $display("FAIL stop_no_start: got %0d starts want 0", fall_cnt - fb); end
        push(8'hD5);
        wait_done(db, 1, 1500);
        n_cmp++; if (done_cnt - db !== 1 || played_q[played_q.size()-1] !== 8'hD5) begin n_fail++; $display("FAIL stop_resume: got done %0d last %h want 1 D5", done_cnt - db, played_q[played_q.size()-1]); end
        wait_quiet("stop");
    endtask

    task automatic test_reset_mid;
        int db, fb, t = 0;
        push(8'h77);
        while (stn !== 1'b0 && t < 50) begin clks(1); t++; end
        n_cmp++; if (stn !== 1'b0) begin n_fail++; $display("FAIL rmid_start: got stn %b want 0", stn); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if ({stn, playing} !== 2'b10) begin n_fail++; $display("FAIL rmid_async: got stn %b playing %b want 1 0", stn, playing); end
        n_cmp++; if (din !== 8'h00 || level !== 3'd0) begin n_fail++; $display("FAIL rmid_state: got din %h level %0d want 00 0", din, level); end
        n_cmp++; if ({done, err, ovf, cmd_full} !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags: got %b want 0000", {done, err, ovf, cmd_full}); end
        clks(2);
        force_busy = 1'b1;
        rstn = 1'b1;
        clks(1);
        db = done_cnt; fb = fall_cnt;
        push(8'h88);
        clks(50);
        n_cmp++; if (fall_cnt - fb !== 0 || level !== 3'd1) begin n_fail++; $display("FAIL rmid_hold: got starts %0d level %0d want 0 1", fall_cnt - fb, level); end
        force_busy = 1'b0;
        wait_done(db, 1, 2500);
        n_cmp++; if (done_cnt - db !== 1 || played_q[played_q.size()-1] !== 8'h88) begin n_fail++; $display("FAIL rmid_resume: got done %0d last %h want 1 88", done_cnt - db, played_q[played_q.size()-1]); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_timeout;
        test_stop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
